// File: rtl/ddr3_pll_phase_pkg.sv
// Shared definitions for the DDR3 PLL phase-adjust controller.
//   state_t  : controller state encoding
//   SEL_OUT* : bit positions within REQ_SEL for each PLL output select
package ddr3_pll_phase_pkg;

  typedef enum logic [2:0] {
    ST_PWRDN,
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_SETUP,
    ST_ROT_HI,
    ST_ROT_GAP,
    ST_LOAD,
    ST_DONE
  } state_t;

  localparam int SEL_OUT0 = 0;
  localparam int SEL_OUT2 = 1;
  localparam int SEL_OUT3 = 2;

endpackage

// File: rtl/ddr3_pll_lock_filter.sv
// PLL lock qualifier: synchronises the asynchronous PLL_LOCK and requires
// LOCK_FILTER consecutive high samples before reporting lock.
//   CLK, RESET_N : fabric clock, async active-low reset
//   CLR          : clears the qualification counter (PLL restart)
//   PLL_LOCK     : raw, asynchronous lock from the PLL
//   LOCKED       : filtered lock status
module ddr3_pll_lock_filter #(
  parameter int LOCK_FILTER = 16
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic CLR,
  input  logic PLL_LOCK,
  output logic LOCKED
);

  localparam int CW = $clog2(LOCK_FILTER + 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values; the synchroniser depends on this ordering.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= PLL_LOCK;
      sync_q2 <= sync_q1;
      // Any synchronised low sample restarts qualification.
      if (CLR || !sync_q2) begin
        cnt <= '0;
      end else if (cnt != CW'(LOCK_FILTER)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign LOCKED = (cnt == CW'(LOCK_FILTER));

endmodule

// File: rtl/ddr3_pll_phase_ctrl.sv
// Fabric-side controller for the CCC/PLL dynamic phase-adjust interface.
// Sequences PLL power-down, qualifies lock, and turns phase-shift commands
// into timed PHASE_ROTATE pulses and an optional LOAD_PHASE_N strobe.
//   CLK, RESET_N            : fabric clock, async active-low reset
//   REQ_VALID/REQ_READY     : command handshake
//   REQ_SEL/DIR/STEPS/LOAD  : command payload, captured on handshake
//   RESTART                 : one-cycle pulse, power-cycles the PLL
//   DONE / ERR              : one-cycle completion / lock-loss abort pulses
//   BUSY, LOCKED            : status
//   PLL_LOCK                : asynchronous lock from the PLL
//   PLL_POWERDOWN_N, PHASE_OUT*_SEL, PHASE_DIRECTION, PHASE_ROTATE,
//   LOAD_PHASE_N            : registered drives to the PLL
module ddr3_pll_phase_ctrl
  import ddr3_pll_phase_pkg::*;
#(
  parameter int ROT_HIGH    = 2,
  parameter int ROT_GAP     = 8,
  parameter int STEP_W      = 8,
  parameter int LOCK_FILTER = 16,
  parameter int PD_CYCLES   = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [2:0]        REQ_SEL,
  input  logic              REQ_DIR,
  input  logic [STEP_W-1:0] REQ_STEPS,
  input  logic              REQ_LOAD,
  input  logic              RESTART,
  output logic              DONE,
  output logic              ERR,
  output logic              BUSY,
  output logic              LOCKED,
  input  logic              PLL_LOCK,
  output logic              PLL_POWERDOWN_N,
  output logic              PHASE_OUT0_SEL,
  output logic              PHASE_OUT2_SEL,
  output logic              PHASE_OUT3_SEL,
  output logic              PHASE_DIRECTION,
  output logic              PHASE_ROTATE,
  output logic              LOAD_PHASE_N
);

  localparam int ROT_MAX = (ROT_HIGH > ROT_GAP) ? ROT_HIGH : ROT_GAP;
  localparam int RC_W    = (ROT_MAX > 1) ? $clog2(ROT_MAX) : 1;
  localparam int PD_W    = (PD_CYCLES > 1) ? $clog2(PD_CYCLES) : 1;

  state_t            state;
  logic [PD_W-1:0]   pd_cnt;
  logic [RC_W-1:0]   rot_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic              cap_load;
  logic [2:0]        phase_sel;
  logic              locked;
  logic              in_cmd;

  ddr3_pll_lock_filter #(
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_filter (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .CLR      (RESTART),
    .PLL_LOCK (PLL_LOCK),
    .LOCKED   (locked)
  );

  assign in_cmd    = state inside {ST_SETUP, ST_ROT_HI, ST_ROT_GAP, ST_LOAD, ST_DONE};
  assign REQ_READY = (state == ST_IDLE) && locked;
  assign BUSY      = (state != ST_IDLE);
  assign LOCKED    = locked;

  assign PHASE_OUT0_SEL = phase_sel[SEL_OUT0];
  assign PHASE_OUT2_SEL = phase_sel[SEL_OUT2];
  assign PHASE_OUT3_SEL = phase_sel[SEL_OUT3];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state           <= ST_PWRDN;
      pd_cnt          <= '0;
      rot_cnt         <= '0;
      step_cnt        <= '0;
      cap_load        <= 1'b0;
      phase_sel       <= 3'b000;
      PHASE_DIRECTION <= 1'b0;
      PHASE_ROTATE    <= 1'b0;
      LOAD_PHASE_N    <= 1'b1;
      PLL_POWERDOWN_N <= 1'b0;
      DONE            <= 1'b0;
      ERR             <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only by the
      // branch that needs them, which keeps them single-cycle.
      DONE <= 1'b0;
      ERR  <= 1'b0;

      if (RESTART) begin
        state           <= ST_PWRDN;
        pd_cnt          <= '0;
        PLL_POWERDOWN_N <= 1'b0;
        phase_sel       <= 3'b000;
        PHASE_DIRECTION <= 1'b0;
        PHASE_ROTATE    <= 1'b0;
        LOAD_PHASE_N    <= 1'b1;
      end else if (in_cmd && !locked) begin
        // Lock lost mid-command: release the PLL controls immediately.
        state           <= ST_WAIT_LOCK;
        ERR             <= 1'b1;
        phase_sel       <= 3'b000;
        PHASE_DIRECTION <= 1'b0;
        PHASE_ROTATE    <= 1'b0;
        LOAD_PHASE_N    <= 1'b1;
      end else begin
        case (state)
          ST_PWRDN: begin
            if (pd_cnt == PD_W'(PD_CYCLES - 1)) begin
              state           <= ST_WAIT_LOCK;
              pd_cnt          <= '0;
              PLL_POWERDOWN_N <= 1'b1;
            end else begin
              pd_cnt <= pd_cnt + 1'b1;
            end
          end

          ST_WAIT_LOCK: begin
            if (locked) state <= ST_IDLE;
          end

          ST_IDLE: begin
            if (!locked) begin
              state <= ST_WAIT_LOCK;
            end else if (REQ_VALID) begin
              state           <= ST_SETUP;
              phase_sel       <= REQ_SEL;
              PHASE_DIRECTION <= REQ_DIR;
              step_cnt        <= REQ_STEPS;
              cap_load        <= REQ_LOAD;
            end
          end

          ST_SETUP: begin
            rot_cnt <= '0;
            if (step_cnt != '0) begin
              state        <= ST_ROT_HI;
              PHASE_ROTATE <= 1'b1;
            end else if (cap_load) begin
              state        <= ST_LOAD;
              LOAD_PHASE_N <= 1'b0;
            end else begin
              state <= ST_DONE;
              DONE  <= 1'b1;
            end
          end

          ST_ROT_HI: begin
            if (rot_cnt == RC_W'(ROT_HIGH - 1)) begin
              state        <= ST_ROT_GAP;
              rot_cnt      <= '0;
              PHASE_ROTATE <= 1'b0;
              if (step_cnt != '0) step_cnt <= step_cnt - 1'b1;
            end else begin
              rot_cnt <= rot_cnt + 1'b1;
            end
          end

          ST_ROT_GAP: begin
            if (rot_cnt == RC_W'(ROT_GAP - 1)) begin
              rot_cnt <= '0;
              if (step_cnt != '0) begin
                state        <= ST_ROT_HI;
                PHASE_ROTATE <= 1'b1;
              end else if (cap_load) begin
                state        <= ST_LOAD;
                LOAD_PHASE_N <= 1'b0;
              end else begin
                state <= ST_DONE;
                DONE  <= 1'b1;
              end
            end else begin
              rot_cnt <= rot_cnt + 1'b1;
            end
          end

          ST_LOAD: begin
            state        <= ST_DONE;
            LOAD_PHASE_N <= 1'b1;
            DONE         <= 1'b1;
          end

          ST_DONE: begin
            state           <= ST_IDLE;
            phase_sel       <= 3'b000;
            PHASE_DIRECTION <= 1'b0;
          end

          default: state <= ST_PWRDN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_pll_phase_ctrl.sv
// Directed bench for ddr3_pll_phase_ctrl. Each command pushes its expected
// result to a scoreboard queue; the entry is popped and compared once the
// DUT completes or aborts the command.
module tb_ddr3_pll_phase_ctrl;

  localparam int ROT_HIGH = 2;
  localparam int ROT_GAP  = 8;
  localparam int PERIOD   = ROT_HIGH + ROT_GAP;

  typedef struct {
    logic [2:0] sel;
    logic       dir;
    int         pulses;
    int         first_rise;
    int         last_rise;
    int         hi;
    int         load_at;
    int         done_at;
    int         err_at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       req_load;
  logic       restart;
  logic       done;
  logic       err;
  logic       busy;
  logic       locked;
  logic       pll_lock;
  logic       pll_powerdown_n;
  logic       out0_sel;
  logic       out2_sel;
  logic       out3_sel;
  logic       phase_dir;
  logic       phase_rotate;
  logic       load_phase_n;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  ddr3_pll_phase_ctrl dut (
    .CLK             (clk),
    .RESET_N         (rst_n),
    .REQ_VALID       (req_valid),
    .REQ_READY       (req_ready),
    .REQ_SEL         (req_sel),
    .REQ_DIR         (req_dir),
    .REQ_STEPS       (req_steps),
    .REQ_LOAD        (req_load),
    .RESTART         (restart),
    .DONE            (done),
    .ERR             (err),
    .BUSY            (busy),
    .LOCKED          (locked),
    .PLL_LOCK        (pll_lock),
    .PLL_POWERDOWN_N (pll_powerdown_n),
    .PHASE_OUT0_SEL  (out0_sel),
    .PHASE_OUT2_SEL  (out2_sel),
    .PHASE_OUT3_SEL  (out3_sel),
    .PHASE_DIRECTION (phase_dir),
    .PHASE_ROTATE    (phase_rotate),
    .LOAD_PHASE_N    (load_phase_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [2:0] sel, input logic dir,
                                    input int steps, input logic load);
    exp_t e;
    e.sel        = sel;
    e.dir        = dir;
    e.pulses     = steps;
    e.first_rise = (steps > 0) ? 2 : -1;
    e.last_rise  = (steps > 0) ? 2 + (steps - 1) * PERIOD : -1;
    e.hi         = steps * ROT_HIGH;
    e.done_at    = 2 + steps * PERIOD + (load ? 1 : 0);
    e.load_at    = load ? e.done_at - 1 : -1;
    e.err_at     = -1;
    return e;
  endfunction

  // Present a command and wait (bounded) for REQ_READY; t0 is the handshake cycle.
  task automatic send(input logic [2:0] sel, input logic dir, input int steps,
                      input logic load, output int t0);
    int n;
    req_sel   = sel;
    req_dir   = dir;
    req_steps = 8'(steps);
    req_load  = load;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    check("handshake_ready", req_ready, 1);
    t0 = cyc;
  endtask

  // Watch the command from SETUP until DONE/ERR, then score it.
  task automatic observe(input int t0, input int drop_at);
    exp_t e;
    int   off, pulses, first_rise, last_rise, hi, load_at, load_cnt, done_at, err_at;
    logic prev_rot;
    logic [2:0] sel_seen;
    logic dir_seen;
    pulses = 0; first_rise = -1; last_rise = -1; hi = 0;
    load_at = -1; load_cnt = 0; done_at = -1; err_at = -1;
    prev_rot = 1'b0;
    tick();
    req_valid = 1'b0;
    sel_seen  = {out3_sel, out2_sel, out0_sel};
    dir_seen  = phase_dir;
    for (int k = 0; k < 1000 && done_at < 0 && err_at < 0; k++) begin
      off = cyc - t0;
      if (phase_rotate) begin
        hi++;
        if (!prev_rot) begin
          pulses++;
          if (first_rise < 0) first_rise = off;
          last_rise = off;
        end
      end
      prev_rot = phase_rotate;
      if (!load_phase_n) begin
        load_cnt++;
        if (load_at < 0) load_at = off;
      end
      if (done) done_at = off;
      if (err) begin
        err_at = off;
        check("abort_rotate", phase_rotate, 0);
        check("abort_sel", {out3_sel, out2_sel, out0_sel}, 0);
        check("abort_load_n", load_phase_n, 1);
        check("abort_ready", req_ready, 0);
        check("abort_busy", busy, 1);
      end
      if (off == drop_at) pll_lock = 1'b0;
      if (done_at < 0 && err_at < 0) tick();
    end
    e = exp_q.pop_front();
    check("setup_sel", sel_seen, e.sel);
    check("setup_dir", dir_seen, e.dir);
    check("rot_pulses", pulses, e.pulses);
    check("rot_first", first_rise, e.first_rise);
    check("rot_last", last_rise, e.last_rise);
    check("rot_hi_cycles", hi, e.hi);
    check("load_at", load_at, e.load_at);
    check("load_cycles", load_cnt, (e.load_at >= 0) ? 1 : 0);
    check("done_at", done_at, e.done_at);
    check("err_at", err_at, e.err_at);
    if (done_at >= 0) begin
      tick();
      check("idle_sel_clear", {out3_sel, out2_sel, out0_sel, phase_dir}, 0);
      check("idle_ready", req_ready, 1);
    end
  endtask

  initial begin
    int t0, r, lk_rise, pd_rise, rdy, pd_low, saw_ed, off;
    exp_t e;

    rst_n = 1'b0; pll_lock = 1'b1; req_valid = 1'b0; req_sel = 3'b000;
    req_dir = 1'b0; req_steps = 8'd0; req_load = 1'b0; restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwrdn_n", pll_powerdown_n, 0);
    check("rst_load_n", load_phase_n, 1);
    check("rst_busy", busy, 1);
    check("rst_rotate", phase_rotate, 0);
    check("rst_sel_dir", {out3_sel, out2_sel, out0_sel, phase_dir}, 0);
    check("rst_pulses", {done, err}, 0);
    check("rst_locked", locked, 0);
    check("rst_ready", req_ready, 0);

    // Power-up: PLL_LOCK high from the start.
    rst_n = 1'b1;
    cyc = 0;
    lk_rise = -1; pd_rise = -1; rdy = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (locked && lk_rise < 0) lk_rise = cyc;
      if (pll_powerdown_n && pd_rise < 0) pd_rise = cyc;
      if (req_ready && rdy < 0) rdy = cyc;
    end
    check("pwrup_locked_cycle", lk_rise, 2 + 16);
    check("pwrup_pd_rise", pd_rise, 32);
    check("pwrup_ready_cycle", rdy, 33);

    // Main command with load, then the two zero-step corner cases, then SEL=0.
    send(3'b101, 1'b1, 3, 1'b1, t0);
    exp_q.push_back(make_exp(3'b101, 1'b1, 3, 1'b1));
    observe(t0, -1);

    send(3'b010, 1'b0, 0, 1'b0, t0);
    exp_q.push_back(make_exp(3'b010, 1'b0, 0, 1'b0));
    observe(t0, -1);

    send(3'b100, 1'b1, 0, 1'b1, t0);
    exp_q.push_back(make_exp(3'b100, 1'b1, 0, 1'b1));
    observe(t0, -1);

    send(3'b000, 1'b0, 1, 1'b0, t0);
    exp_q.push_back(make_exp(3'b000, 1'b0, 1, 1'b0));
    observe(t0, -1);

    // Lock dropped one cycle into the second gap: two synchroniser flops,
    // one counter clear, then the abort edge.
    send(3'b011, 1'b1, 3, 1'b1, t0);
    e = make_exp(3'b011, 1'b1, 3, 1'b1);
    e.pulses = 2; e.last_rise = 2 + PERIOD; e.hi = 2 * ROT_HIGH;
    e.load_at = -1; e.done_at = -1; e.err_at = 15 + 4;
    exp_q.push_back(e);
    observe(t0, 15);
    tick();
    check("post_abort_ready", req_ready, 0);
    check("post_abort_busy", busy, 1);
    repeat (3) tick();

    // Re-lock: LOCKED after 2 + 16 cycles, READY the cycle after.
    r = cyc;
    pll_lock = 1'b1;
    lk_rise = -1; rdy = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (locked && lk_rise < 0) lk_rise = cyc - r;
      if (req_ready && rdy < 0) rdy = cyc - r;
    end
    check("relock_locked", lk_rise, 18);
    check("relock_ready", rdy, 19);

    // RESTART on the first ROT_HI cycle with REQ_VALID held high throughout.
    send(3'b110, 1'b0, 2, 1'b1, t0);
    tick();
    tick();
    check("pre_restart_rotate", phase_rotate, 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_rotate", phase_rotate, 0);
    check("restart_locked", locked, 0);
    pd_low = 0; pd_rise = -1; lk_rise = -1; rdy = -1; saw_ed = 0;
    for (int k = 0; k < 100 && rdy < 0; k++) begin
      off = cyc - t0;
      if (!pll_powerdown_n) pd_low++;
      else if (pd_rise < 0) pd_rise = off;
      if (locked && lk_rise < 0) lk_rise = off;
      if (done || err) saw_ed++;
      if (req_ready) rdy = off;
      else tick();
    end
    check("restart_pd_low", pd_low, 32);
    check("restart_pd_rise", pd_rise, 3 + 32);
    check("restart_locked_rise", lk_rise, 3 + 16);
    check("restart_no_done_err", saw_ed, 0);
    check("restart_ready_at", rdy, 3 + 32 + 1);

    // The held request is accepted now and runs to completion.
    exp_q.push_back(make_exp(3'b110, 1'b0, 2, 1'b1));
    observe(cyc, -1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
